// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM responder: command encodings, mode-register
// field positions, burst-state encoding and the burst-length decode.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_LOAD_MODE = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVE    = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_BTERM     = 3'b110,
        CMD_NOP       = 3'b111
    } sdram_cmd_e;

    typedef enum logic [1:0] {
        BST_IDLE  = 2'd0,
        BST_READ  = 2'd1,
        BST_WRITE = 2'd2
    } burst_state_e;

    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;

    function automatic logic [3:0] burst_len(input logic [2:0] field);
        case (field)
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// SDR SDRAM pin bundle between a controller (master) and the responder (slave).
// Valid/ready does not apply here: every command is sampled on each posedge when cke=1 and ncs=0.
interface sdram_responder_if #(
    parameter int SDRAM_ADDRESS_WIDTH = 13,
    parameter int BANK_BITS           = 2
);
    logic                           sdram_cke;
    logic                           sdram_ncs;
    logic                           sdram_ras;
    logic                           sdram_cas;
    logic                           sdram_nwe;
    logic [SDRAM_ADDRESS_WIDTH-1:0] sdram_address;
    logic [BANK_BITS-1:0]           sdram_ba;
    logic [1:0]                     sdram_dqm;
    logic [15:0]                    sdram_data_in;
    logic [15:0]                    sdram_data_out;
    logic                           sdram_data_oe;
    logic                           error;
    logic                           mode_loaded;

    modport master (
        output sdram_cke, sdram_ncs, sdram_ras, sdram_cas, sdram_nwe,
        output sdram_address, sdram_ba, sdram_dqm, sdram_data_in,
        input  sdram_data_out, sdram_data_oe, error, mode_loaded
    );

    modport slave (
        input  sdram_cke, sdram_ncs, sdram_ras, sdram_cas, sdram_nwe,
        input  sdram_address, sdram_ba, sdram_dqm, sdram_data_in,
        output sdram_data_out, sdram_data_oe, error, mode_loaded
    );
endinterface

// File: rtl/sdram_responder_mem.sv
// Backing store: 16-bit synchronous RAM, per-byte write enables, registered read.
module sdram_responder_mem #(
    parameter int MEM_ADDRESS_WIDTH = 14
) (
    input  logic                         clk,
    input  logic [MEM_ADDRESS_WIDTH-1:0] addr_i,
    input  logic [1:0]                   we_i,
    input  logic [15:0]                  wdata_i,
    output logic [15:0]                  rdata_o
);
    logic [15:0] mem_q [0:(1<<MEM_ADDRESS_WIDTH)-1];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
        if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device responder backed by block RAM: bank/row tracking, mode register,
// CAS latency, wrapped bursts, auto-precharge, sticky error. Optional SDRAM_RESPONDER_TIMING_CHECK_EN.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int SDRAM_ADDRESS_WIDTH        = 13,
    parameter int SDRAM_COLUMN_ADDRESS_WIDTH = 9,
    parameter int BANK_BITS                  = 2,
    parameter int MEM_ADDRESS_WIDTH          = 14,
    parameter int DEFAULT_MODE               = 'h21
) (
    input  logic             clk,
    input  logic             nreset,
    sdram_responder_if.slave bus,
    output burst_state_e     burst_state_o
);
    localparam int AW = SDRAM_ADDRESS_WIDTH;
    localparam int CW = SDRAM_COLUMN_ADDRESS_WIDTH;
    localparam int MW = MEM_ADDRESS_WIDTH;
    localparam int NB = 1 << BANK_BITS;
    localparam logic [6:0] DEF_MODE = 7'(DEFAULT_MODE);

    sdram_cmd_e           cmd;
    logic [BANK_BITS-1:0] ba;
    logic [AW-1:0]        addr;
    assign cmd  = (bus.sdram_cke && !bus.sdram_ncs) ?
                  sdram_cmd_e'({bus.sdram_ras, bus.sdram_cas, bus.sdram_nwe}) : CMD_NOP;
    assign ba   = bus.sdram_ba;
    assign addr = bus.sdram_address;

    logic [2:0]    bl_field_q, bl_field_d, cl_field_q, cl_field_d;
    logic          mode_loaded_q, mode_loaded_d, error_q, error_d;
    logic [NB-1:0] bank_act_q, bank_act_d, close;
    logic [AW-1:0] bank_row_q [NB];
    logic [AW-1:0] bank_row_d [NB];

    burst_state_e         state_q, state_d;
    logic [3:0]           beat_q, beat_d, blen_q, blen_d;
    logic [BANK_BITS-1:0] bba_q, bba_d;
    logic [AW-1:0]        brow_q, brow_d;
    logic [CW-1:0]        bcol_q, bcol_d;
    logic                 bap_q, bap_d;

    logic          rd_v1_q, pipe_v_q, oe_q;
    logic [15:0]   pipe_data_q, dout_q, mem_rdata;
    logic [MW-1:0] mem_addr;
    logic [1:0]    mem_we;
    logic          rd_issue, timing_err;

    logic [3:0] bl_cur;
    logic       cl3, is_rw, rw_ok, in_burst, last_beat;
    assign bl_cur    = burst_len(bl_field_q);
    assign cl3       = (cl_field_q == 3'd3);
    assign is_rw     = (cmd == CMD_READ) || (cmd == CMD_WRITE);
    assign rw_ok     = is_rw && bank_act_q[ba];
    assign in_burst  = (state_q != BST_IDLE);
    assign last_beat = in_burst && (beat_q == blen_q - 4'd1);

    function automatic logic [MW-1:0] lin(input logic [BANK_BITS-1:0] b,
                                          input logic [AW-1:0] r, input logic [CW-1:0] c);
        logic [BANK_BITS+AW+CW-1:0] full;
        full = {b, r, c};
        return full[MW-1:0];
    endfunction

    // Sequential beat order: only the low log2(BL) column bits advance and wrap.
    function automatic logic [CW-1:0] beat_col(input logic [CW-1:0] start,
                                               input logic [3:0] k, input logic [3:0] bl);
        logic [CW-1:0] m;
        m = CW'(bl - 4'd1);
        return (start & ~m) | ((start + CW'(k)) & m);
    endfunction

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bl_field_q    <= DEF_MODE[2:0];
            cl_field_q    <= DEF_MODE[6:4];
            mode_loaded_q <= 1'b0;
            error_q       <= 1'b0;
            bank_act_q    <= '0;
            for (int b = 0; b < NB; b++) bank_row_q[b] <= '0;
            state_q       <= BST_IDLE;
            beat_q        <= '0;
            blen_q        <= 4'd1;
            bba_q         <= '0;
            brow_q        <= '0;
            bcol_q        <= '0;
            bap_q         <= 1'b0;
            rd_v1_q       <= 1'b0;
            pipe_v_q      <= 1'b0;
            pipe_data_q   <= '0;
            oe_q          <= 1'b0;
            dout_q        <= '0;
        end else begin
            bl_field_q    <= bl_field_d;
            cl_field_q    <= cl_field_d;
            mode_loaded_q <= mode_loaded_d;
            error_q       <= error_d;
            bank_act_q    <= bank_act_d;
            bank_row_q    <= bank_row_d;
            state_q       <= state_d;
            beat_q        <= beat_d;
            blen_q        <= blen_d;
            bba_q         <= bba_d;
            brow_q        <= brow_d;
            bcol_q        <= bcol_d;
            bap_q         <= bap_d;
            // RAM read is stage one; CL-1 further stages reach the pins.
            rd_v1_q       <= rd_issue;
            pipe_v_q      <= rd_v1_q;
            pipe_data_q   <= mem_rdata;
            oe_q          <= cl3 ? pipe_v_q : rd_v1_q;
            dout_q        <= cl3 ? (pipe_v_q ? pipe_data_q : 16'h0) : (rd_v1_q ? mem_rdata : 16'h0);
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        blen_d  = blen_q;
        bba_d   = bba_q;
        brow_d  = brow_q;
        bcol_d  = bcol_q;
        bap_d   = bap_q;
        if (rw_ok) begin
            blen_d = bl_cur;
            beat_d = 4'd1;
            bba_d  = ba;
            brow_d = bank_row_q[ba];
            bcol_d = addr[CW-1:0];
            bap_d  = addr[10];
            if (bl_cur == 4'd1)        state_d = BST_IDLE;
            else if (cmd == CMD_WRITE) state_d = BST_WRITE;
            else                       state_d = BST_READ;
        end else if (in_burst) begin
            beat_d = beat_q + 4'd1;
            if (last_beat) state_d = BST_IDLE;
        end
    end

    always_comb begin
        mem_addr = lin(ba, bank_row_q[ba], addr[CW-1:0]);
        mem_we   = 2'b00;
        rd_issue = 1'b0;
        if (rw_ok) begin
            if (cmd == CMD_WRITE) mem_we = ~bus.sdram_dqm;
            else                  rd_issue = 1'b1;
        end else if (in_burst) begin
            mem_addr = lin(bba_q, brow_q, beat_col(bcol_q, beat_q, blen_q));
            if (state_q == BST_WRITE) mem_we = ~bus.sdram_dqm;
            else                      rd_issue = 1'b1;
        end
    end

    always_comb begin
        close = '0;
        // An auto-precharging burst closes on its last beat or when a new burst cuts it short.
        if (in_burst && bap_q && (last_beat || rw_ok)) close[bba_q] = 1'b1;
        if (rw_ok && addr[10] && bl_cur == 4'd1) close[ba] = 1'b1;
        if (cmd == CMD_PRECHARGE) begin
            if (addr[10]) close = '1;
            else          close[ba] = 1'b1;
        end
        bank_act_d = bank_act_q & ~close;
        bank_row_d = bank_row_q;
        if (cmd == CMD_ACTIVE) begin
            bank_act_d[ba] = 1'b1;
            bank_row_d[ba] = addr;
        end
    end

    always_comb begin
        bl_field_d    = bl_field_q;
        cl_field_d    = cl_field_q;
        mode_loaded_d = mode_loaded_q;
        error_d       = error_q;
        if (cmd == CMD_LOAD_MODE) begin
            bl_field_d    = addr[MODE_BL_MSB:MODE_BL_LSB];
            cl_field_d    = addr[MODE_CL_MSB:MODE_CL_LSB];
            mode_loaded_d = 1'b1;
        end
        if (!mode_loaded_q && !(cmd inside {CMD_LOAD_MODE, CMD_NOP, CMD_PRECHARGE})) error_d = 1'b1;
        if (cmd == CMD_ACTIVE && bank_act_q[ba])  error_d = 1'b1;
        if (is_rw && !bank_act_q[ba])             error_d = 1'b1;
        if (cmd == CMD_REFRESH && |bank_act_q)    error_d = 1'b1;
        if (timing_err)                           error_d = 1'b1;
    end

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
    localparam logic [1:0] T_RCD = 2'd2;
    localparam logic [1:0] T_RP  = 2'd2;
    localparam logic [1:0] T_RFC = 2'd3;

    // Saturating "cycles since event" counters; reset to saturation so nothing trips early.
    logic [1:0] act_cnt_q [NB];
    logic [1:0] rp_cnt_q  [NB];
    logic [1:0] rfc_cnt_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int b = 0; b < NB; b++) begin
                act_cnt_q[b] <= 2'd3;
                rp_cnt_q[b]  <= 2'd3;
            end
            rfc_cnt_q <= 2'd3;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (cmd == CMD_ACTIVE && ba == BANK_BITS'(b)) act_cnt_q[b] <= 2'd1;
                else if (act_cnt_q[b] != 2'd3)                act_cnt_q[b] <= act_cnt_q[b] + 2'd1;
                if (close[b])                                 rp_cnt_q[b]  <= 2'd1;
                else if (rp_cnt_q[b] != 2'd3)                 rp_cnt_q[b]  <= rp_cnt_q[b] + 2'd1;
            end
            if (cmd == CMD_REFRESH)      rfc_cnt_q <= 2'd1;
            else if (rfc_cnt_q != 2'd3)  rfc_cnt_q <= rfc_cnt_q + 2'd1;
        end
    end

    assign timing_err = (is_rw && act_cnt_q[ba] < T_RCD) ||
                        (cmd == CMD_ACTIVE && rp_cnt_q[ba] < T_RP) ||
                        (cmd != CMD_NOP && rfc_cnt_q < T_RFC);
`else
    assign timing_err = 1'b0;
`endif

    sdram_responder_mem #(.MEM_ADDRESS_WIDTH(MW)) u_mem (
        .clk     (clk),
        .addr_i  (mem_addr),
        .we_i    (mem_we),
        .wdata_i (bus.sdram_data_in),
        .rdata_o (mem_rdata)
    );

    assign bus.sdram_data_out = dout_q;
    assign bus.sdram_data_oe  = oe_q;
    assign bus.error          = error_q;
    assign bus.mode_loaded    = mode_loaded_q;
    assign burst_state_o      = state_q;
endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: directed scenarios plus randomized bursts
// checked against a word-array memory model and an expected-read queue.
module tb_sdram_responder;
    import sdram_pkg::*;

    localparam logic [2:0] C_LOAD = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_NOP = 3'b111;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    sdram_responder_if bus();
    burst_state_e burst_state;

    sdram_responder dut (
        .clk           (clk),
        .nreset        (nreset),
        .bus           (bus),
        .burst_state_o (burst_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_mem [0:16383];
    logic [12:0] open_row [4];
    int model_bl = 2;
    int model_cl = 2;
    logic [15:0] wd [8];
    logic [1:0]  wm [8];
    logic [15:0] last_rd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one command cycle; returns #1 after the edge that samples it.
    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] m);
        bus.sdram_cke     = 1'b1;
        bus.sdram_ncs     = 1'b0;
        {bus.sdram_ras, bus.sdram_cas, bus.sdram_nwe} = c;
        bus.sdram_ba      = b;
        bus.sdram_address = a;
        bus.sdram_data_in = d;
        bus.sdram_dqm     = m;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        bus.sdram_cke = 1'b1;
        bus.sdram_ncs = 1'b1;
        {bus.sdram_ras, bus.sdram_cas, bus.sdram_nwe} = C_NOP;
        bus.sdram_ba = '0; bus.sdram_address = '0; bus.sdram_data_in = '0; bus.sdram_dqm = '0;
        @(posedge clk); @(posedge clk); #1;
        nreset = 1'b1;
        model_bl = 2;
        model_cl = 2;
    endtask

    function automatic int bl_of(input logic [12:0] m);
        case (m[2:0])
            3'd1: return 2;
            3'd2: return 4;
            3'd3: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int lin_addr(input logic [1:0] b, input logic [12:0] r, input int col);
        return (int'(b) * 4194304 + int'(r) * 512 + col) % 16384;
    endfunction

    function automatic int beat_col(input int col, input int k, input int bl);
        return (col / bl) * bl + ((col % bl) + k) % bl;
    endfunction

    task automatic load_mode(input logic [12:0] m);
        drive(C_LOAD, 2'd0, m, 16'd0, 2'b00);
        model_bl = bl_of(m);
        model_cl = (m[6:4] == 3'd3) ? 3 : 2;
    endtask

    task automatic activate(input logic [1:0] b, input logic [12:0] r);
        drive(C_ACT, b, r, 16'd0, 2'b00);
        open_row[b] = r;
    endtask

    task automatic write_burst(input logic [1:0] b, input int col, input logic ap);
        for (int k = 0; k < model_bl; k++) begin
            int a;
            a = lin_addr(b, open_row[b], beat_col(col, k, model_bl));
            if (!wm[k][0]) model_mem[a][7:0]  = wd[k][7:0];
            if (!wm[k][1]) model_mem[a][15:8] = wd[k][15:8];
            if (k == 0) drive(C_WR, b, 13'(col) | (13'(ap) << 10), wd[k], wm[k]);
            else        drive(C_NOP, 2'd0, 13'd0, wd[k], wm[k]);
        end
    endtask

    // Beat k must be on the pins for the edge CL+k after the command edge.
    task automatic read_burst(input logic [1:0] b, input int col, input logic ap, input string tag);
        int bl, cl;
        bl = model_bl;
        cl = model_cl;
        for (int k = 0; k < bl; k++)
            exp_q.push_back(model_mem[lin_addr(b, open_row[b], beat_col(col, k, bl))]);
        drive(C_RD, b, 13'(col) | (13'(ap) << 10), 16'd0, 2'b00);
        for (int t = 0; t < cl + bl; t++) begin
            if (t > 0) nop(1);
            if (t >= cl - 1 && t < cl - 1 + bl) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (t == cl - 1) last_rd0 = bus.sdram_data_out;
                check_eq({tag, "_oe"}, bus.sdram_data_oe, 1'b1);
                check_eq({tag, "_data"}, bus.sdram_data_out, e);
            end else if (t == cl - 1 + bl) begin
                check_eq({tag, "_oe_end"}, bus.sdram_data_oe, 1'b0);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        check_eq("rst_oe", bus.sdram_data_oe, 1'b0);
        check_eq("rst_dout", bus.sdram_data_out, 16'h0);
        check_eq("rst_err", bus.error, 1'b0);
        check_eq("rst_mode_loaded", bus.mode_loaded, 1'b0);

        // Directed: BL2/CL2 auto-precharge write then read back.
        load_mode(13'h21);
        check_eq("mode_loaded", bus.mode_loaded, 1'b1);
        activate(2'd1, 13'h123);
        nop(2);
        wd[0] = 16'h1111; wd[1] = 16'h2222; wm[0] = 2'b00; wm[1] = 2'b00;
        write_burst(2'd1, 'h040, 1'b1);
        check_eq("wr_err", bus.error, 1'b0);
        nop(1);
        activate(2'd1, 13'h123);
        check_eq("reactivate_err", bus.error, 1'b0);
        nop(2);
        read_burst(2'd1, 'h040, 1'b1, "rd_bl2");
        check_eq("rd_bl2_beat0", last_rd0, 16'h1111);

        // BL4/CL3 wrap: written at col 4..7, read starting at col 6.
        load_mode(13'h32);
        nop(2);
        activate(2'd2, 13'h055);
        nop(2);
        for (int k = 0; k < 4; k++) begin wd[k] = 16'hA0 + 16'(k); wm[k] = 2'b00; end
        write_burst(2'd2, 'h004, 1'b0);
        read_burst(2'd2, 'h006, 1'b0, "rd_wrap");
        check_eq("rd_wrap_beat0", last_rd0, 16'h00A2);

        // Byte mask: upper byte masked over 0x1234.
        for (int k = 0; k < 4; k++) begin wd[k] = 16'h1234; wm[k] = 2'b00; end
        write_burst(2'd2, 'h010, 1'b0);
        for (int k = 0; k < 4; k++) begin wd[k] = 16'hBEEF; wm[k] = 2'b10; end
        write_burst(2'd2, 'h010, 1'b0);
        read_burst(2'd2, 'h010, 1'b0, "rd_mask");
        check_eq("rd_mask_beat0", last_rd0, 16'h12EF);
        drive(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        nop(2);
        check_eq("directed_err", bus.error, 1'b0);

        // Randomized bursts over random mode, bank, row and column.
        for (int it = 0; it < 24; it++) begin
            logic [2:0] clf, blf;
            logic [1:0] b;
            logic [12:0] r;
            int col;
            logic ap;
            blf = 3'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0: clf = 3'd2;
                1: clf = 3'd3;
                2: clf = 3'd1;
                default: clf = 3'd7;
            endcase
            load_mode({6'd0, clf, 1'b0, blf});
            nop(1);
            b = 2'($urandom_range(0, 3));
            r = 13'($urandom);
            col = $urandom_range(0, 511);
            ap = 1'($urandom);
            activate(b, r);
            nop(2);
            for (int k = 0; k < 8; k++) begin wd[k] = 16'($urandom); wm[k] = 2'b00; end
            write_burst(b, col, 1'b0);
            for (int k = 0; k < 8; k++) begin wd[k] = 16'($urandom); wm[k] = 2'($urandom); end
            write_burst(b, col, 1'b0);
            read_burst(b, col, ap, "rnd");
            drive(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
            nop(2);
            check_eq("rnd_err", bus.error, 1'b0);
        end

        // Protocol violations.
        do_reset();
        load_mode(13'h21);
        nop(1);
        drive(C_RD, 2'd0, 13'h000, 16'd0, 2'b00);
        check_eq("idle_read_err", bus.error, 1'b1);
        for (int t = 0; t < 4; t++) begin
            check_eq("idle_read_oe", bus.sdram_data_oe, 1'b0);
            nop(1);
        end
        do_reset();
        load_mode(13'h21);
        activate(2'd0, 13'h001);
        nop(2);
        check_eq("pre_ref_err", bus.error, 1'b0);
        drive(C_REF, 2'd0, 13'h000, 16'd0, 2'b00);
        check_eq("ref_active_err", bus.error, 1'b1);
        do_reset();
        check_eq("err_cleared", bus.error, 1'b0);
        check_eq("mode_loaded_cleared", bus.mode_loaded, 1'b0);

        // READ one cycle after ACTIVE; RAM contents survive reset.
        load_mode(13'h21);
        activate(2'd1, 13'h123);
        read_burst(2'd1, 'h040, 1'b0, "rd_early");
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
        check_eq("trcd_err", bus.error, 1'b1);
`else
        check_eq("trcd_err", bus.error, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
